// File: rtl/sram_controller_pkg.sv
// Shared types and constants for the 32-bit over 16-bit SRAM data-memory controller.
package sram_controller_pkg;

  typedef enum logic [1:0] {IDLE, LO, HI, DONE} state_e;

  localparam logic [31:0] BASE_ADDR_DEF = 32'd1024;
  localparam int          SRAM_ADDR_W   = 18;
  localparam int          SRAM_DATA_W   = 16;
  localparam int          WORD_W        = SRAM_ADDR_W - 1;

  // Byte address to SRAM word index; subtraction wraps and the result is truncated.
  function automatic logic [WORD_W-1:0] sram_word(input logic [31:0] addr,
                                                  input logic [31:0] base);
    return WORD_W'((addr - base) >> 2);
  endfunction

endpackage

// File: rtl/sram_controller_wait_counter.sv
// Per-half wait counter: cleared outside a half and on its last cycle, otherwise counts up.
module sram_controller_wait_counter #(
  parameter int unsigned SRAM_WAIT = 2
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic clr_i,
  input  logic inc_i,
  output logic tc_o,
  output logic last_nxt_o
);

  logic [3:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (inc_i) begin
      cnt_d = cnt_q + 4'd1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // last_nxt_o tells the FSM whether the coming cycle is the final one of a half.
  assign tc_o       = (cnt_q == 4'(SRAM_WAIT - 1));
  assign last_nxt_o = (cnt_d == 4'(SRAM_WAIT - 1));

endmodule

// File: rtl/sram_controller.sv
// Splits each 32-bit MEM-stage access into two timed 16-bit asynchronous SRAM accesses.
// state | meaning
// IDLE  | no access; ready follows the enables
// LO    | low half-word held on the SRAM pins
// HI    | high half-word held on the SRAM pins
// DONE  | access finished, ready=1 for one cycle
module sram_controller
  import sram_controller_pkg::*;
#(
  parameter int unsigned SRAM_WAIT = 2,
  parameter logic [31:0] BASE_ADDR = BASE_ADDR_DEF
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   wr_en_i,
  input  logic                   rd_en_i,
  input  logic [31:0]            address_i,
  input  logic [31:0]            wdata_i,
  output logic [31:0]            rdata_o,
  output logic                   ready_o,
  inout  wire  [SRAM_DATA_W-1:0] sram_dq_io,
  output logic [SRAM_ADDR_W-1:0] sram_addr_o,
  output logic                   sram_we_n_o,
  output logic                   sram_oe_n_o,
  output logic                   sram_ce_n_o,
  output logic                   sram_ub_n_o,
  output logic                   sram_lb_n_o
);

  state_e                 state_q;
  logic                   wr_q;
  logic [SRAM_DATA_W-1:0] wdata_hi_q;
  logic [SRAM_DATA_W-1:0] rdata_lo_q;
  logic [31:0]            rdata_q;
  logic [SRAM_ADDR_W-1:0] sram_addr_q;
  logic                   we_n_q;
  logic                   dq_oe_q;
  logic [SRAM_DATA_W-1:0] dq_out_q;

  logic req, busy, tc, last_nxt;

  assign req  = wr_en_i | rd_en_i;
  assign busy = (state_q == LO) || (state_q == HI);

  sram_controller_wait_counter #(.SRAM_WAIT(SRAM_WAIT)) u_wait (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .clr_i      (!busy || tc),
    .inc_i      (busy),
    .tc_o       (tc),
    .last_nxt_o (last_nxt)
  );

  // WE_N is computed one cycle ahead so the last cycle of every write half is a data-hold cycle.
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      state_q     <= IDLE;
      wr_q        <= 1'b0;
      wdata_hi_q  <= '0;
      rdata_lo_q  <= '0;
      rdata_q     <= '0;
      sram_addr_q <= '0;
      we_n_q      <= 1'b1;
      dq_oe_q     <= 1'b0;
      dq_out_q    <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (req) begin
            state_q     <= LO;
            wr_q        <= wr_en_i;
            wdata_hi_q  <= wdata_i[31:16];
            sram_addr_q <= {sram_word(address_i, BASE_ADDR), 1'b0};
            we_n_q      <= !(wr_en_i && !last_nxt);
            dq_oe_q     <= wr_en_i;
            dq_out_q    <= wdata_i[15:0];
          end
        end
        LO: begin
          we_n_q <= !(wr_q && !last_nxt);
          if (tc) begin
            state_q        <= HI;
            sram_addr_q[0] <= 1'b1;
            dq_out_q       <= wdata_hi_q;
            if (!wr_q) begin
              rdata_lo_q <= sram_dq_io;
            end
          end
        end
        HI: begin
          if (tc) begin
            state_q <= DONE;
            we_n_q  <= 1'b1;
            dq_oe_q <= 1'b0;
            if (!wr_q) begin
              rdata_q <= {sram_dq_io, rdata_lo_q};
            end
          end else begin
            we_n_q <= !(wr_q && !last_nxt);
          end
        end
        DONE:    state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  assign ready_o     = ((state_q == IDLE) && !req) || (state_q == DONE);
  assign rdata_o     = rdata_q;
  assign sram_addr_o = sram_addr_q;
  assign sram_we_n_o = we_n_q;
  assign sram_dq_io  = dq_oe_q ? dq_out_q : 'z;
  assign sram_oe_n_o = 1'b0;
  assign sram_ce_n_o = 1'b0;
  assign sram_ub_n_o = 1'b0;
  assign sram_lb_n_o = 1'b0;

endmodule

// File: tb/tb_sram_controller.sv
// Bench for sram_controller: directed vector table, reset corner cases and randomized traffic.
module tb_sram_controller;

  localparam int W = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic        wr_en, rd_en;
  logic [31:0] address, wdata;
  logic [31:0] rdata;
  logic        ready;
  wire  [15:0] sram_dq;
  logic [17:0] sram_addr;
  logic        sram_we_n, sram_oe_n, sram_ce_n, sram_ub_n, sram_lb_n;

  always #5 clk = ~clk;

  sram_controller #(.SRAM_WAIT(W), .BASE_ADDR(32'd1024)) dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .wr_en_i     (wr_en),
    .rd_en_i     (rd_en),
    .address_i   (address),
    .wdata_i     (wdata),
    .rdata_o     (rdata),
    .ready_o     (ready),
    .sram_dq_io  (sram_dq),
    .sram_addr_o (sram_addr),
    .sram_we_n_o (sram_we_n),
    .sram_oe_n_o (sram_oe_n),
    .sram_ce_n_o (sram_ce_n),
    .sram_ub_n_o (sram_ub_n),
    .sram_lb_n_o (sram_lb_n)
  );

  // Asynchronous SRAM model: drives the bus only while the bench has a load in flight.
  logic [15:0] sram_mem [0:262143];
  logic        rd_phase = 1'b0;

  assign sram_dq = (rd_phase && sram_we_n) ? sram_mem[sram_addr] : 16'bz;

  always @(posedge clk) begin
    if (!sram_we_n) sram_mem[sram_addr] <= sram_dq;
  end

  // Reference: half-word image of everything stored, plus the load data last expected.
  logic [15:0] ref_mem [int];
  logic [31:0] exp_rdata_g = '0;

  int checks = 0;
  int errors = 0;

  typedef struct {
    bit          w;
    bit          r;
    logic [31:0] a;
    logic [31:0] d;
    logic [17:0] base;
    logic [31:0] exp_rd;
  } vec_t;

  vec_t tbl [8];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Entry and exit: just after a rising edge with the controller idle.
  task automatic run_txn(input bit w, input bit r, input logic [31:0] a, input logic [31:0] d,
                         input logic [17:0] base, input bit chk_rd, input logic [31:0] exp_rd,
                         input string nm);
    wr_en = w; rd_en = r; address = a; wdata = d;
    rd_phase = r && !w;
    @(negedge clk);
    chk({nm, ".ready_req"}, {31'b0, ready}, 32'd0);
    @(posedge clk); #1;
    for (int h = 0; h < 2; h++) begin
      for (int c = 0; c < W; c++) begin
        wr_en = 1'($urandom_range(0, 1)); rd_en = 1'($urandom_range(0, 1));
        address = $urandom; wdata = $urandom;
        @(negedge clk);
        chk({nm, ".ready_busy"}, {31'b0, ready}, 32'd0);
        chk({nm, ".addr"}, {14'b0, sram_addr}, {14'b0, base} + 32'(h));
        chk({nm, ".we_n"}, {31'b0, sram_we_n}, (w && c != W - 1) ? 32'd0 : 32'd1);
        if (w) chk({nm, ".dq"}, {16'b0, sram_dq}, {16'b0, (h == 1) ? d[31:16] : d[15:0]});
        @(posedge clk); #1;
      end
    end
    @(negedge clk);
    chk({nm, ".ready_done"}, {31'b0, ready}, 32'd1);
    chk({nm, ".we_n_done"}, {31'b0, sram_we_n}, 32'd1);
    if (chk_rd) chk({nm, ".rdata"}, rdata, exp_rd);
    @(posedge clk); #1;
    wr_en = 1'b0; rd_en = 1'b0; rd_phase = 1'b0;
    @(negedge clk);
    chk({nm, ".ready_idle"}, {31'b0, ready}, 32'd1);
    if (chk_rd) chk({nm, ".rdata_hold"}, rdata, exp_rd);
    @(posedge clk); #1;
  endtask

  task automatic do_op(input bit w, input bit r, input logic [31:0] a, input logic [31:0] d);
    logic [31:0] off;
    logic [17:0] base;
    off  = (a - 32'd1024) >> 2;
    base = {off[16:0], 1'b0};
    if (w) begin
      ref_mem[int'(base)]     = d[15:0];
      ref_mem[int'(base) + 1] = d[31:16];
    end else if (ref_mem.exists(int'(base)) && ref_mem.exists(int'(base) + 1)) begin
      exp_rdata_g = {ref_mem[int'(base) + 1], ref_mem[int'(base)]};
    end
    run_txn(w, r, a, d, base, 1'b1, exp_rdata_g, "rand");
  endtask

  initial begin
    tbl[0] = '{1'b1, 1'b0, 32'd1028, 32'hDEADBEEF, 18'd2,      32'h00000000};
    tbl[1] = '{1'b0, 1'b1, 32'd1028, 32'h0,        18'd2,      32'hDEADBEEF};
    tbl[2] = '{1'b1, 1'b0, 32'd1032, 32'h12345678, 18'd4,      32'hDEADBEEF};
    tbl[3] = '{1'b1, 1'b1, 32'd1024, 32'hCAFEF00D, 18'd0,      32'hDEADBEEF};
    tbl[4] = '{1'b0, 1'b1, 32'd1024, 32'h0,        18'd0,      32'hCAFEF00D};
    tbl[5] = '{1'b1, 1'b0, 32'd0,    32'hA5A55A5A, 18'h3FE00,  32'hCAFEF00D};
    tbl[6] = '{1'b0, 1'b1, 32'd0,    32'h0,        18'h3FE00,  32'hA5A55A5A};
    tbl[7] = '{1'b0, 1'b1, 32'd1032, 32'h0,        18'd4,      32'h12345678};

    // Power-on reset held two cycles with a load pending.
    rst = 1'b0; wr_en = 1'b0; rd_en = 1'b1; address = 32'd1100; wdata = '0;
    for (int i = 0; i < 2; i++) begin
      @(posedge clk); #1;
      @(negedge clk);
      chk("rst.ready", {31'b0, ready}, 32'd0);
      chk("rst.rdata", rdata, 32'd0);
      chk("rst.we_n", {31'b0, sram_we_n}, 32'd1);
      chk("rst.addr", {14'b0, sram_addr}, 32'd0);
    end
    @(posedge clk); #1;
    rst = 1'b1;
    run_txn(1'b0, 1'b1, 32'd1100, 32'h0, 18'd38, 1'b0, 32'h0, "rst_release");

    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("idle.ready", {31'b0, ready}, 32'd1);
      chk("idle.we_n", {31'b0, sram_we_n}, 32'd1);
      @(posedge clk); #1;
    end

    rst = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    @(negedge clk);
    chk("pulse.rdata", rdata, 32'd0);
    @(posedge clk); #1;

    for (int i = 0; i < 8; i++) begin
      if (tbl[i].w) begin
        ref_mem[int'(tbl[i].base)]     = tbl[i].d[15:0];
        ref_mem[int'(tbl[i].base) + 1] = tbl[i].d[31:16];
      end
      run_txn(tbl[i].w, tbl[i].r, tbl[i].a, tbl[i].d, tbl[i].base, 1'b1, tbl[i].exp_rd,
              $sformatf("vec%0d", i));
    end
    exp_rdata_g = 32'h12345678;

    // Reset during the second HI cycle of a load.
    wr_en = 1'b0; rd_en = 1'b1; address = 32'd1028; rd_phase = 1'b1;
    for (int i = 0; i < 2 * W; i++) begin
      @(posedge clk); #1;
    end
    rst = 1'b0;
    @(posedge clk); #1;
    @(negedge clk);
    chk("midrst.rdata", rdata, 32'd0);
    chk("midrst.ready_en", {31'b0, ready}, 32'd0);
    chk("midrst.addr", {14'b0, sram_addr}, 32'd0);
    chk("midrst.we_n", {31'b0, sram_we_n}, 32'd1);
    rd_en = 1'b0; rd_phase = 1'b0;
    #1;
    chk("midrst.ready_noen", {31'b0, ready}, 32'd1);
    rst = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    chk("midrst.idle", {31'b0, ready}, 32'd1);
    @(posedge clk); #1;
    exp_rdata_g = 32'd0;

    for (int k = 0; k < 128; k++) do_op(1'b1, 1'b0, 32'd1024 + 32'(4 * k), $urandom);

    for (int n = 0; n < 60; n++) begin
      int op;
      int gap;
      op  = $urandom_range(0, 2);
      gap = $urandom_range(0, 2);
      do_op(op != 1, op != 0, 32'd1024 + 32'(4 * $urandom_range(0, 127)) + 32'($urandom_range(0, 3)),
            $urandom);
      for (int g = 0; g < gap; g++) begin
        @(negedge clk);
        chk("rand.gap_ready", {31'b0, ready}, 32'd1);
        @(posedge clk); #1;
      end
    end

    foreach (ref_mem[k]) chk($sformatf("sweep[%0h]", k), {16'b0, sram_mem[k]}, {16'b0, ref_mem[k]});
    chk("tied_pins", {28'b0, sram_oe_n, sram_ce_n, sram_ub_n, sram_lb_n}, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
